// File: rtl/debug_probe_display.sv
// debug_probe_display: picks one probe word (live or from a frozen snapshot,
// manually selected or auto-cycled) and presents a DIGITS-nibble window of it
// to the 7-segment driver. All outputs are registered.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LIVE   | show iwProbes, index follows iwSel
// FROZEN | show snapshot register, index follows iwSel
// AUTO   | show iwProbes, index advances every DWELL clocks
module debug_probe_display #(
    parameter int NUM_PROBES = 8,
    parameter int PROBE_W    = 32,
    parameter int DIGITS     = 4,
    parameter int DWELL      = 100000000,
    parameter int SEL_W      = 3,
    parameter int WIN_W      = 1
) (
    input  logic                          iwClk,
    input  logic                          iwnRst,
    input  logic [NUM_PROBES*PROBE_W-1:0] iwProbes,
    input  logic [SEL_W-1:0]              iwSel,
    input  logic [1:0]                    iwMode,
    input  logic                          iwCapture,
    input  logic                          iwPanStep,
    output logic [DIGITS*4-1:0]           owData,
    output logic [SEL_W-1:0]              owIndex,
    output logic [WIN_W-1:0]              owWindow,
    output logic                          owFrozen
);

    localparam int NIBS  = (PROBE_W + 3) / 4;
    localparam int WINS  = (NIBS + DIGITS - 1) / DIGITS;
    localparam int EXT_W = 4 * DIGITS * WINS;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] INDEX_LAST = SEL_W'(NUM_PROBES - 1);
    localparam logic [WIN_W-1:0] WINDOW_LAST = WIN_W'(WINS - 1);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        FROZEN = 2'd1,
        AUTO   = 2'd2
    } viewStateT;

    viewStateT                   rState;
    viewStateT                   modeState;
    logic [NUM_PROBES*PROBE_W-1:0] rSnapshot;
    logic [SEL_W-1:0]            rIndex;
    logic [WIN_W-1:0]            rWindow;
    logic [CNT_W-1:0]            rDwell;
    logic                        rCapPrev;
    logic                        rPanPrev;

    logic                        capEdge;
    logic                        panEdge;
    logic                        snapLoad;
    logic [SEL_W-1:0]            indexNext;
    logic [WIN_W-1:0]            windowNext;
    logic [CNT_W-1:0]            dwellNext;
    logic [NUM_PROBES*PROBE_W-1:0] srcAll;
    logic [PROBE_W-1:0]          srcWord;
    logic [EXT_W-1:0]            srcExt;
    logic [DIGITS*4-1:0]         windowData;

    // Decode the requested mode and the rising edges of the level requests.
    always_comb begin
        case (iwMode)
            2'b01:   modeState = FROZEN;
            2'b10:   modeState = AUTO;
            default: modeState = LIVE;
        endcase
        capEdge  = iwCapture & ~rCapPrev;
        panEdge  = iwPanStep & ~rPanPrev;
        // Entry into FROZEN and a capture edge in the same cycle is still one load.
        snapLoad = ((modeState == FROZEN) && (rState != FROZEN)) || capEdge;
    end

    // Next index, dwell count and window; an index change always resets the window.
    always_comb begin
        indexNext  = rIndex;
        dwellNext  = '0;
        windowNext = rWindow;
        if (modeState == AUTO) begin
            if (rState == AUTO) begin
                if (rDwell == DWELL_LAST) begin
                    dwellNext = '0;
                    indexNext = (rIndex == INDEX_LAST) ? '0 : rIndex + 1'b1;
                end else begin
                    dwellNext = rDwell + 1'b1;
                end
            end
        end else if (int'(iwSel) < NUM_PROBES) begin
            indexNext = iwSel;
        end
        if (indexNext != rIndex) begin
            windowNext = '0;
        end else if (panEdge) begin
            windowNext = (rWindow == WINDOW_LAST) ? '0 : rWindow + 1'b1;
        end
    end

    // Select the source word and cut out the displayed nibble window.
    always_comb begin
        srcAll                = (rState == FROZEN) ? rSnapshot : iwProbes;
        srcWord               = srcAll[rIndex*PROBE_W +: PROBE_W];
        srcExt                = '0;
        srcExt[PROBE_W-1:0]   = srcWord;
        windowData            = srcExt[int'(rWindow)*DIGITS*4 +: DIGITS*4];
    end

    // Snapshot of every probe, taken on FROZEN entry or a capture edge.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rSnapshot <= '0;
        end else if (snapLoad) begin
            rSnapshot <= iwProbes;
        end
    end

    // Viewer state machine plus the registered display outputs.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rState   <= LIVE;
            rIndex   <= '0;
            rWindow  <= '0;
            rDwell   <= '0;
            rCapPrev <= 1'b1;
            rPanPrev <= 1'b1;
            owData   <= '0;
            owIndex  <= '0;
            owWindow <= '0;
            owFrozen <= 1'b0;
        end else begin
            rState   <= modeState;
            rIndex   <= indexNext;
            rWindow  <= windowNext;
            rDwell   <= dwellNext;
            rCapPrev <= iwCapture;
            rPanPrev <= iwPanStep;
            owData   <= windowData;
            owIndex  <= rIndex;
            owWindow <= rWindow;
            owFrozen <= (rState == FROZEN);
        end
    end

endmodule

// File: tb/tb_debug_probe_display.sv
// Bench for debug_probe_display: directed scenarios with literal expectations,
// then randomized traffic, all continuously compared against a behavioural model.
module tb_debug_probe_display;

    localparam int NP   = 4;
    localparam int PW   = 32;
    localparam int DG   = 4;
    localparam int DW   = 5;
    localparam int SW   = 2;
    localparam int WW   = 1;
    localparam int WINS = 2;

    logic              clk = 1'b0;
    logic              rstN = 1'b1;
    logic [NP*PW-1:0]  probes = '0;
    logic [SW-1:0]     sel = '0;
    logic [1:0]        mode = 2'b00;
    logic              cap = 1'b1;
    logic              pan = 1'b1;
    logic [DG*4-1:0]   data;
    logic [SW-1:0]     idx;
    logic [WW-1:0]     win;
    logic              frozen;

    int nTests = 0;
    int nFail  = 0;
    bit checkOn = 1'b0;

    debug_probe_display #(
        .NUM_PROBES(NP), .PROBE_W(PW), .DIGITS(DG), .DWELL(DW), .SEL_W(SW), .WIN_W(WW)
    ) dut (
        .iwClk(clk), .iwnRst(rstN), .iwProbes(probes), .iwSel(sel), .iwMode(mode),
        .iwCapture(cap), .iwPanStep(pan), .owData(data), .owIndex(idx),
        .owWindow(win), .owFrozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setProbe(input int k, input logic [31:0] v);
        probes[k*PW +: PW] = v;
    endtask

    function automatic logic [31:0] probeOf(input int k);
        return probes[k*PW +: PW];
    endfunction

    // Behavioural model: mode 0 live, 1 frozen, 2 auto; words held as plain arrays.
    int          mMode, mIdx, mWin, mCnt;
    bit          mCapPrev, mPanPrev;
    logic [31:0] mSnap [NP];
    logic [15:0] eData;
    int          eIdx, eWin;
    bit          eFrozen;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mMode <= 0; mIdx <= 0; mWin <= 0; mCnt <= 0;
            mCapPrev <= 1'b1; mPanPrev <= 1'b1;
            for (int k = 0; k < NP; k++) mSnap[k] <= '0;
            eData <= '0; eIdx <= 0; eWin <= 0; eFrozen <= 1'b0;
        end else begin : modelStep
            int cur, nIdx, nCnt, nWin;
            logic [31:0] word;
            bit capE, panE;
            cur  = (mode == 2'b01) ? 1 : (mode == 2'b10) ? 2 : 0;
            capE = cap && !mCapPrev;
            panE = pan && !mPanPrev;
            word = (mMode == 1) ? mSnap[mIdx] : probeOf(mIdx);
            eData   <= 16'(word >> (16 * mWin));
            eIdx    <= mIdx;
            eWin    <= mWin;
            eFrozen <= (mMode == 1);
            if ((cur == 1 && mMode != 1) || capE)
                for (int k = 0; k < NP; k++) mSnap[k] <= probeOf(k);
            nIdx = mIdx;
            nCnt = 0;
            if (cur == 2) begin
                if (mMode == 2) begin
                    nCnt = mCnt + 1;
                    if (nCnt == DW) begin
                        nCnt = 0;
                        nIdx = (mIdx + 1) % NP;
                    end
                end
            end else begin
                nIdx = int'(sel);
            end
            if (nIdx != mIdx) nWin = 0;
            else if (panE)    nWin = (mWin + 1) % WINS;
            else              nWin = mWin;
            mMode <= cur; mIdx <= nIdx; mCnt <= nCnt; mWin <= nWin;
            mCapPrev <= cap; mPanPrev <= pan;
        end
    end

    // Every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            chk("cyc data",   data,   eData);
            chk("cyc index",  idx,    eIdx);
            chk("cyc window", win,    eWin);
            chk("cyc frozen", frozen, eFrozen);
        end
    end

    initial begin
        // 1: reset with capture/pan held high; no edge at release.
        #1 rstN = 1'b0;
        checkOn = 1'b1;
        #20;
        @(posedge clk); #1 rstN = 1'b1;
        cyc(3);
        chk("t1 data", data, 16'h0000);
        chk("t1 index", idx, 0);
        chk("t1 window", win, 0);
        chk("t1 frozen", frozen, 0);
        cap = 1'b0; pan = 1'b0;
        cyc(1);

        // 2: live view with panning.
        setProbe(2, 32'h89ABCDEF);
        sel = 2;
        cyc(2);
        chk("t2 data", data, 16'hCDEF);
        chk("t2 model", eData, 16'hCDEF);
        chk("t2 index", idx, 2);
        pan = 1'b1; cyc(1); pan = 1'b0; cyc(1);
        chk("t2 pan data", data, 16'h89AB);
        chk("t2 pan window", win, 1);
        pan = 1'b1; cyc(1); pan = 1'b0; cyc(1);
        chk("t2 wrap data", data, 16'hCDEF);
        chk("t2 wrap window", win, 0);

        // 3: frozen snapshot and recapture.
        setProbe(1, 32'h11112222);
        setProbe(3, 32'hDEADBEEF);
        sel = 1;
        cyc(2);
        mode = 2'b01;
        cyc(1);
        setProbe(1, 32'h33334444);
        setProbe(3, 32'h0BADF00D);
        cyc(2);
        chk("t3 frozen data", data, 16'h2222);
        chk("t3 frozen flag", frozen, 1);
        sel = 3;
        cyc(2);
        chk("t3 probe3 snap", data, 16'hBEEF);
        chk("t3 model snap", eData, 16'hBEEF);
        sel = 1;
        cyc(2);
        chk("t3 back", data, 16'h2222);
        cap = 1'b1; cyc(1); cap = 1'b0; cyc(2);
        chk("t3 recapture", data, 16'h4444);

        // 4: auto-cycle from index 3.
        mode = 2'b00;
        for (int k = 0; k < NP; k++) setProbe(k, 32'hA0 + k);
        sel = 3;
        cyc(2);
        chk("t4 start index", idx, 3);
        mode = 2'b10;
        cyc(1);
        chk("t4 entry index", idx, 3);
        chk("t4 entry data", data, 16'h00A3);
        cyc(5);
        chk("t4 hold index", idx, 3);
        cyc(1);
        chk("t4 adv0 index", idx, 0);
        chk("t4 adv0 data", data, 16'h00A0);
        cyc(4);
        chk("t4 hold0 index", idx, 0);
        cyc(1);
        chk("t4 adv1 index", idx, 1);
        chk("t4 adv1 data", data, 16'h00A1);
        cyc(5);
        chk("t4 adv2 index", idx, 2);
        chk("t4 adv2 data", data, 16'h00A2);
        chk("t4 model index", eIdx, 2);

        // 5: pan on the advance cycle is overridden; elsewhere it pans.
        cyc(3);
        pan = 1'b1; cyc(1); pan = 1'b0; cyc(1);
        chk("t5 adv index", idx, 3);
        chk("t5 adv window", win, 0);
        pan = 1'b1; cyc(1); pan = 1'b0; cyc(1);
        chk("t5 pan window", win, 1);
        chk("t5 pan data", data, 16'h0000);

        // 6: asynchronous reset mid-dwell.
        #2 rstN = 1'b0;
        #1;
        chk("t6 async index", idx, 0);
        chk("t6 async window", win, 0);
        chk("t6 async data", data, 16'h0000);
        @(posedge clk); #1 rstN = 1'b1;
        cyc(1);
        chk("t6 entry index", idx, 0);
        cyc(5);
        chk("t6 hold index", idx, 0);
        cyc(1);
        chk("t6 adv index", idx, 1);
        chk("t6 adv data", data, 16'h00A1);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0)
                for (int k = 0; k < NP; k++) setProbe(k, $urandom);
            sel = SW'($urandom_range(0, NP - 1));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            cap = ($urandom_range(0, 7) == 0);
            pan = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rstN = 1'b0;
                cyc(1);
                rstN = 1'b1;
            end
            cyc(1);
        end

        checkOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/debug_probe_display.md
Name: debug_probe_display

Overview:
Parametrised debug viewer between CPU probe signals and the 7-segment display driver. Selects one of NUM_PROBES probe words and presents a DIGITS-nibble window of it. Supports panning across wide probes, freezing a snapshot of all probes for browsing, and auto-cycling through probes. Registered outputs feed the display driver's digit inputs directly.

Parameters:
NUM_PROBES, 8, number of probe channels (>=2)
PROBE_W, 32, bits per probe
DIGITS, 4, nibbles shown per window
DWELL, 100000000, clocks per probe in auto-cycle mode (>=1)
SEL_W, 3, index width, must equal clog2(NUM_PROBES)
WIN_W, 1, window index width, must cover WINS = ceil(ceil(PROBE_W/4)/DIGITS) (min 1)

Ports:
iwClk  in  1  system clock
iwnRst  in  1  reset; asynchronous, active-low
iwProbes  in  NUM_PROBES*PROBE_W  probe k at [k*PROBE_W +: PROBE_W]
iwSel  in  SEL_W  manual probe select
iwMode  in  2  00 live, 01 frozen, 10 auto-cycle, 11 = live
iwCapture  in  1  snapshot request, level; rising edge acts
iwPanStep  in  1  pan request, level; rising edge acts
owData  out  DIGITS*4  digit i at [4i+3:4i], digit 0 least significant
owIndex  out  SEL_W  probe index currently displayed
owWindow  out  WIN_W  window currently displayed
owFrozen  out  1  high while showing snapshot data

Behaviour:
- Reset (iwnRst low, async): rIndex=0, rWindow=0, snapshot=0, dwell counter=0, owData=0, owFrozen=0, state LIVE. Edge-detect prev registers reset to 1, so an input already high at release yields no edge.
- All inputs synchronous to iwClk. Edge = input high and prev low.
- States LIVE, FROZEN, AUTO follow iwMode each cycle (11 -> LIVE).
- Snapshot: full NUM_PROBES*PROBE_W register. Loaded on the cycle iwMode enters FROZEN from another state, and on any capture edge in any state. Entry plus capture edge in the same cycle: one load.
- Source: FROZEN uses snapshot, LIVE/AUTO use iwProbes. owFrozen=1 in FROZEN only.
- Index, LIVE/FROZEN: rIndex <= iwSel each cycle. iwSel >= NUM_PROBES: rIndex holds its previous value.
- Index, AUTO: on entry the dwell counter clears and rIndex holds. Counter counts 0..DWELL-1. At DWELL-1, rIndex <= rIndex+1, wrapping NUM_PROBES-1 -> 0, and the counter returns to 0. iwSel is ignored.
- Window: a pan edge advances rWindow, wrapping WINS-1 -> 0. Any cycle where rIndex changes forces rWindow=0, overriding a simultaneous pan edge. WINS=1: rWindow stays 0.
- Nibbles: the probe is zero-extended to 4*DIGITS*WINS bits. Digit i shows nibble rWindow*DIGITS+i of the selected source word.
- Latency: owData, owIndex, owWindow are registered from the current rIndex, rWindow and source. A probe value change appears 1 cycle later. An iwSel change appears on owIndex after 2 edges and on owData after 2 edges.
- Reset mid-operation: all state returns to reset values immediately, including the snapshot and the dwell count.

Test Plan:
Config for all: NUM_PROBES=4, PROBE_W=32, DIGITS=4, DWELL=5, SEL_W=2, WIN_W=1.
1. Reset with iwCapture=iwPanStep=1 held, release, hold 3 cycles -> owData=0000, owIndex=0, owWindow=0, no snapshot load, no pan.
2. LIVE, probe2=0x89ABCDEF, iwSel=2 -> 2 edges later owData=0xCDEF, owIndex=2. One pan pulse -> owData=0x89AB, owWindow=1. Second pulse -> wraps to 0xCDEF.
3. Probe1=0x11112222, enter FROZEN with iwSel=1, then change probe1 to 0x33334444 -> owData stays 0x2222, owFrozen=1. iwSel=3 shows snapshotted probe3. Capture pulse -> probe1 now reads 0x4444.
4. AUTO from index 3, probes 0..3 = 0xA0,0xA1,0xA2,0xA3 -> owIndex sequence 3,0,1,2 advancing every 5 cycles; owData low byte tracks it.
5. AUTO, pan edge on the exact cycle rIndex advances -> owWindow=0. A pan edge on a non-advance cycle -> owWindow=1.
6. Mid-AUTO at dwell count 3 and window 1, pulse iwnRst low for 1 cycle -> owIndex=0, owWindow=0, owData=0 asynchronously. The next advance occurs 5 cycles after release plus the AUTO entry.
